muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the RV32M/RV64M instruction group. It sits beside the ALU in the execute stage and takes its operands after forwarding. It holds the pipeline through `stall_o` until the result is ready. Compared with the fixed single-radix path in the current ALU, it adds:
- generic width;
- configurable bits-per-cycle for multiply and divide independently;
- explicit start/done handshake;
- flush abort;
- sign fix-up for all eight M-extension operations.

---
 rtl/muldiv_unit_pkg.sv | 31 +++
 rtl/muldiv_unit_step.sv | 69 ++++++
 rtl/muldiv_unit.sv | 201 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: muldiv_op_e (RV32M/RV64M op encodings 0-7), muldiv_state_e (FSM states).
package ceres_param;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } muldiv_state_e;

  // Ops 4..7 are the divide family.
  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One iteration of BPC radix-2 steps: shift-add multiply or restoring divide.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: hi_i/hi_o  upper product half or XLEN+1 bit partial remainder
//        lo_i/lo_o  multiplier bits (shifted out LSB first) or dividend/quotient
//        opnd_i     multiplicand or divisor magnitude
module muldiv_step #(
  parameter int XLEN   = 32,
  parameter int BPC    = 1,
  parameter bit IS_DIV = 1'b0
) (
  input  logic [XLEN:0]   hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN:0]   hi_o,
  output logic [XLEN-1:0] lo_o
);

  if (IS_DIV) begin : g_div
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;
    logic [XLEN+1:0] shifted;
    logic [XLEN:0]   diff;
    logic            fits;

    // Dividend bits leave quo at the MSB while quotient bits enter at the LSB.
    always_comb begin
      rem     = hi_i;
      quo     = lo_i;
      shifted = '0;
      diff    = '0;
      fits    = 1'b0;
      for (int k = 0; k < BPC; k++) begin
        shifted = {rem, quo[XLEN-1]};
        fits    = (shifted >= {2'b00, opnd_i});
        // Only taken when fits, so the true difference is below the divisor.
        diff    = shifted[XLEN:0] - {1'b0, opnd_i};
        rem     = fits ? diff : shifted[XLEN:0];
        quo     = {quo[XLEN-2:0], fits};
      end
    end

    assign hi_o = rem;
    assign lo_o = quo;
  end else begin : g_mul
    logic [XLEN:0]   acc;
    logic [XLEN-1:0] mlt;
    logic [XLEN-1:0] addend;
    logic [XLEN+1:0] sum;

    // Right-shifting product: the carry lands in acc, the sum LSB drops into lo.
    always_comb begin
      acc    = hi_i;
      mlt    = lo_i;
      addend = '0;
      sum    = '0;
      for (int k = 0; k < BPC; k++) begin
        addend = mlt[0] ? opnd_i : '0;
        sum    = {1'b0, acc} + {2'b00, addend};
        acc    = sum[XLEN+1:1];
        mlt    = {sum[0], mlt[XLEN-1:1]};
      end
    end

    assign hi_o = acc;
    assign lo_o = mlt;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with start/done handshake and flush abort.
// Latency: XLEN/MUL_BPC+2 or XLEN/DIV_BPC+2 cycles start to done (1 for early-out cases).
// Backpressure: stall_o holds the pipeline from accepted start until the DONE cycle.
// Ports: clk_i, rst_ni (async active-low), flush_i, start_i, op_i, a_i, b_i in;
//        busy_o, done_o (1-cycle pulse), result_o (held), stall_o (combinational) out.
// Option: MULDIV_EARLY_OUT_EN sends divide-by-zero, signed overflow and zero-operand
//         multiplies from IDLE straight to DONE.
module muldiv_unit
  import ceres_param::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 1,
  parameter int DIV_BPC = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            start_i,
  input  muldiv_op_e      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            stall_o
);

  localparam int              CW      = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   MUL_CNT = CW'(XLEN / MUL_BPC);
  localparam logic [CW-1:0]   DIV_CNT = CW'(XLEN / DIV_BPC);

  muldiv_state_e   state, state_nx;
  logic [CW-1:0]   cnt;
  muldiv_op_e      op_q;
  logic [XLEN:0]   hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opnd_q;
  logic            neg_res;
  logic            neg_rem;
  logic [XLEN-1:0] result_q;

  // Operand conditioning for the incoming request.
  logic            is_div_op, a_signed, b_signed, a_neg, b_neg, b_zero;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            early;
  logic [XLEN-1:0] early_res;

  always_comb begin
    is_div_op = op_is_div(op_i);
    a_signed  = (op_i == MULH) || (op_i == MULHSU) || (op_i == DIV) || (op_i == REM);
    b_signed  = (op_i == MULH) || (op_i == DIV) || (op_i == REM);
    a_neg     = a_signed && a_i[XLEN-1];
    b_neg     = b_signed && b_i[XLEN-1];
    a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag     = b_neg ? (~b_i + 1'b1) : b_i;
    b_zero    = (b_i == '0);
  end

`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    early     = 1'b0;
    early_res = '0;
    if (is_div_op) begin
      if (b_zero) begin
        early     = 1'b1;
        early_res = ((op_i == DIV) || (op_i == DIVU)) ? '1 : a_i;
      end else if (((op_i == DIV) || (op_i == REM)) &&
                   (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1)) begin
        early     = 1'b1;
        early_res = (op_i == DIV) ? a_i : '0;
      end
    end else if ((a_i == '0) || b_zero) begin
      early     = 1'b1;
      early_res = '0;
    end
  end
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  // Iteration datapaths.
  logic [XLEN:0]   mul_hi, div_hi;
  logic [XLEN-1:0] mul_lo, div_lo;

  muldiv_step #(.XLEN(XLEN), .BPC(MUL_BPC), .IS_DIV(1'b0)) u_mul_step (
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .opnd_i (opnd_q),
    .hi_o   (mul_hi),
    .lo_o   (mul_lo)
  );

  muldiv_step #(.XLEN(XLEN), .BPC(DIV_BPC), .IS_DIV(1'b1)) u_div_step (
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .opnd_i (opnd_q),
    .hi_o   (div_hi),
    .lo_o   (div_lo)
  );

  // Sign fix-up and result selection from the finished iteration registers.
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  always_comb begin
    prod     = {hi_q[XLEN-1:0], lo_q};
    prod_fix = neg_res ? (~prod + 1'b1) : prod;
    quot_fix = neg_res ? (~lo_q + 1'b1) : lo_q;
    rem_fix  = neg_rem ? (~hi_q[XLEN-1:0] + 1'b1) : hi_q[XLEN-1:0];
    fix_res  = '0;
    case (op_q)
      MUL:                   fix_res = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU:   fix_res = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:             fix_res = quot_fix;
      REM, REMU:             fix_res = rem_fix;
      default:               fix_res = '0;
    endcase
  end

  // FSM next state and outputs.
  always_comb begin
    state_nx = state;
    busy_o   = (state != ST_IDLE);
    done_o   = (state == ST_DONE);
    stall_o  = (start_i && (state == ST_IDLE)) ||
               (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIXUP);
    case (state)
      ST_IDLE:
        if (start_i) begin
          if (early)          state_nx = ST_DONE;
          else if (is_div_op) state_nx = ST_DIV;
          else                state_nx = ST_MUL;
        end
      ST_MUL, ST_DIV:
        if (cnt == CW'(1)) state_nx = ST_FIXUP;
      ST_FIXUP: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    // An abort always wins, including over a start arriving in IDLE.
    if (flush_i) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
    end else begin
      state <= state_nx;
      if (flush_i) begin
        cnt <= '0;
      end else begin
        case (state)
          ST_IDLE:
            if (start_i) begin
              op_q <= op_i;
              hi_q <= '0;
              if (is_div_op) begin
                lo_q    <= a_mag;
                opnd_q  <= b_mag;
                cnt     <= DIV_CNT;
                // A zero divisor must leave the all-ones quotient unsigned.
                neg_res <= (a_neg ^ b_neg) && !b_zero;
                neg_rem <= a_neg;
              end else begin
                lo_q    <= b_mag;
                opnd_q  <= a_mag;
                cnt     <= MUL_CNT;
                neg_res <= a_neg ^ b_neg;
                neg_rem <= 1'b0;
              end
              if (early) result_q <= early_res;
            end
          ST_MUL: begin
            hi_q <= mul_hi;
            lo_q <= mul_lo;
            cnt  <= cnt - CW'(1);
          end
          ST_DIV: begin
            hi_q <= div_hi;
            lo_q <= div_lo;
            cnt  <= cnt - CW'(1);
          end
          ST_FIXUP: result_q <= fix_res;
          default: ;
        endcase
      end
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: two instances (BPC 1/1 and MUL 4 / DIV 2) share stimulus;
// an arithmetic reference model predicts done cycle and result, checked every cycle.
module tb_muldiv_unit;
  import ceres_param::*;

  localparam int MBPC [2] = '{1, 4};
  localparam int DBPC [2] = '{1, 2};
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  muldiv_op_e  op    = MUL;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;

  logic        busy0, done0, stall0, busy1, done1, stall1;
  logic [31:0] res0, res1;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  muldiv_unit #(.XLEN(32), .MUL_BPC(1), .DIV_BPC(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .start_i(start), .op_i(op),
    .a_i(a), .b_i(b), .busy_o(busy0), .done_o(done0), .result_o(res0), .stall_o(stall0)
  );

  muldiv_unit #(.XLEN(32), .MUL_BPC(4), .DIV_BPC(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .start_i(start), .op_i(op),
    .a_i(a), .b_i(b), .busy_o(busy1), .done_o(done1), .result_o(res1), .stall_o(stall1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the RISC-V M rules.
  function automatic logic [31:0] ref_model(input muldiv_op_e o, input logic [31:0] x,
                                            input logic [31:0] y);
    logic [63:0] p;
    int sx, sy;
    logic ovf;
    sx  = $signed(x);
    sy  = $signed(y);
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      MUL:    begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      MULH:   begin p = longint'(sx) * longint'(sy); return p[63:32]; end
      MULHSU: begin p = longint'(sx) * longint'({32'b0, y}); return p[63:32]; end
      MULHU:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      DIV:    return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy);
      DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      REM:    return (y == 0) ? x : ovf ? 32'h0 : 32'(sx % sy);
      REMU:   return (y == 0) ? x : x % y;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int lat_of(input int i, input muldiv_op_e o, input logic [31:0] x,
                                input logic [31:0] y);
    logic is_div;
    is_div = (o == DIV) || (o == DIVU) || (o == REM) || (o == REMU);
    if (EO) begin
      if (is_div && y == 0) return 1;
      if ((o == DIV || o == REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      if (!is_div && (x == 0 || y == 0)) return 1;
    end
    return (is_div ? 32 / DBPC[i] : 32 / MBPC[i]) + 2;
  endfunction

  // Per-instance model: idle/active, predicted done cycle, pending and held result.
  bit          m_act [2];
  int          m_dc  [2];
  logic [31:0] m_res [2];
  logic [31:0] m_pend[2];

  task automatic model_step(input int i, input logic bz, input logic dn, input logic st,
                            input logic [31:0] r);
    logic e_done;
    if (!rst_n) begin
      m_act[i] = 1'b0;
      m_res[i] = '0;
      check($sformatf("rst_busy%0d", i), bz, 0);
      check($sformatf("rst_done%0d", i), dn, 0);
      check($sformatf("rst_result%0d", i), r, 0);
      check($sformatf("rst_stall%0d", i), st, start);
    end else begin
      e_done = m_act[i] && (cyc == m_dc[i]);
      check($sformatf("busy%0d", i), bz, m_act[i]);
      check($sformatf("done%0d", i), dn, e_done);
      check($sformatf("stall%0d", i), st, (start && !m_act[i]) || (m_act[i] && !e_done));
      check($sformatf("result%0d", i), r, e_done ? m_pend[i] : m_res[i]);
      if (e_done) begin
        m_res[i] = m_pend[i];
        m_act[i] = 1'b0;
      end else if (flush) begin
        m_act[i] = 1'b0;
      end else if (!m_act[i] && start) begin
        m_act[i]  = 1'b1;
        m_dc[i]   = cyc + lat_of(i, op, a, b);
        m_pend[i] = ref_model(op, a, b);
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, busy0, done0, stall0, res0);
    model_step(1, busy1, done1, stall1, res1);
  end

  // Issue one op from the current cycle; literal result and latencies for both instances.
  task automatic run_op(input muldiv_op_e o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_r, input int l0, input int l1);
    int t0, d0, d1, guard;
    t0 = cyc; d0 = -1; d1 = -1; guard = 0;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while ((d0 < 0 || d1 < 0) && guard < 200) begin
      @(negedge clk);
      guard++;
      if (done0 && d0 < 0) begin d0 = cyc - t0; check("lit_res0", res0, exp_r); end
      if (done1 && d1 < 0) begin d1 = cyc - t0; check("lit_res1", res1, exp_r); end
    end
    check("lit_lat0", d0, l0);
    check("lit_lat1", d1, l1);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t;
    // Pin the reference model against hand-computed values.
    check("ref_mulhu", ref_model(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("ref_div", ref_model(DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("ref_rem", ref_model(REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("ref_mulh", ref_model(MULH, 32'hFFFF_FFFE, 32'd3), 32'hFFFF_FFFF);
    check("ref_rem_by0", ref_model(REM, 32'hFFFF_FFF9, 32'd0), 32'hFFFF_FFF9);
    check("ref_mul", ref_model(MUL, 32'h1234_5678, 32'h9ABC_DEF0), 32'h242D_2080);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 10);
    run_op(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 18);
    run_op(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 18);
    run_op(MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, 10);
    run_op(DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, EO ? 1 : 34, EO ? 1 : 18);
    run_op(REMU,   32'd5,         32'd0,         32'd5,         EO ? 1 : 34, EO ? 1 : 18);
    run_op(DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, EO ? 1 : 34, EO ? 1 : 18);
    run_op(REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, EO ? 1 : 34, EO ? 1 : 18);
    run_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EO ? 1 : 34, EO ? 1 : 18);
    run_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         EO ? 1 : 34, EO ? 1 : 18);
    run_op(MUL,    32'd0,         32'd5,         32'h0,         EO ? 1 : 34, EO ? 1 : 10);
    run_op(MUL,    32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, 34, 10);
    run_op(DIVU,   32'd1000,      32'd7,         32'd142,       34, 18);

    // Flush mid-divide: back to IDLE, result untouched, then a fresh multiply.
    t = cyc;
    op = DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t + 10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy0", busy0, 0);
    check("flush_busy1", busy1, 0);
    check("flush_res0", res0, 32'd142);
    check("flush_res1", res1, 32'd142);
    @(posedge clk); #1;
    run_op(MUL, 32'd3, 32'd4, 32'd12, 34, 10);

    // Flush together with start in IDLE: the request is dropped.
    op = MUL; a = 32'd3; b = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy0", busy0, 0);
    check("flush_start_busy1", busy1, 0);

    // Asynchronous reset in the middle of a multiply.
    op = MUL; a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy0", busy0, 0);
    check("arst_done0", done0, 0);
    check("arst_res0", res0, 0);
    check("arst_stall0", stall0, 0);
    check("arst_res1", res1, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 10);

    // Random traffic: starts while busy, occasional flushes, special operand values.
    repeat (4000) begin
      op    = muldiv_op_e'($urandom_range(0, 7));
      a     = rand_opnd();
      b     = rand_opnd();
      start = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    flush = 1'b0;
    repeat (60) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
